uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the single UART transmitter on the clk1 domain.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rr_pick.sv | 52 +++++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter: default
//               payload width, arbiter state encoding and a helper that sizes
//               the start-timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default payload width; must match the transmitter data port.
    localparam int c_DATA_W = 8;

    // Arbiter/sequencer state encoding.
    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_LOAD       = 2'd1;
    localparam logic [1:0] c_ST_WAIT_START = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE  = 2'd3;

    // Width of a counter that must hold values 0 .. max_count-1 (at least 1 bit).
    function automatic int cnt_width(input int max_count);
        if (max_count > 1) begin
            return $clog2(max_count);
        end
        return 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Selects the first valid
//               requester at or after the priority pointer, wrapping modulo
//               N_REQ.
// Ports       : i_req_valid - per-requester valid
//               i_ptr       - highest-priority index this round (< N_REQ)
//               o_any       - at least one requester valid
//               o_winner    - index of selected requester
//               o_onehot    - one-hot of o_winner, all zero when !o_any
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_winner,
    output logic [N_REQ-1:0] o_onehot
);

    // Rotate the valid vector so bit k corresponds to requester (ptr+k) mod N.
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W:0]   w_idx;

    assign w_rot = N_REQ'({i_req_valid, i_req_valid} >> i_ptr);

    // Scan from the farthest offset down to offset 0 so the nearest valid
    // requester is the last one written and therefore wins.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = {1'b0, i_ptr} + (IDX_W + 1)'(i);
                if (w_idx >= (IDX_W + 1)'(N_REQ)) begin
                    w_idx = w_idx - (IDX_W + 1)'(N_REQ);
                end
                o_any    = 1'b1;
                o_winner = w_idx[IDX_W-1:0];
            end
        end
    end

    assign o_onehot = o_any ? (N_REQ'(1) << o_winner) : '0;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter and sequencer feeding one byte at a time
//               to a single UART transmitter. Parity configuration is latched
//               per frame; a transmitter that never reports busy after a start
//               pulse is flagged and the byte is dropped.
// Ports       : clk1            - single clock
//               rst             - synchronous reset, active low
//               req_valid/data  - per-requester byte offer
//               req_ready       - one-hot accept (IDLE only)
//               cfg_parity_*    - requested parity settings
//               tx_data/_valid  - byte and one-cycle start pulse to transmitter
//               tx_parity_*     - frame-stable parity settings
//               tx_busy         - transmitter shifting a frame
//               grant_id        - owner of current/last frame
//               timeout_err     - one-cycle pulse, transmitter never started
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = c_DATA_W,
    parameter int START_TIMEOUT = 16
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      cfg_parity_en,
    input  logic                      cfg_parity_type,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_data_valid,
    output logic                      tx_parity_en,
    output logic                      tx_parity_type,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      timeout_err
);

    localparam int                 c_IDX_W    = $clog2(N_REQ);
    localparam int                 c_CNT_W    = cnt_width(START_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_tx_data;
    logic [c_IDX_W-1:0] r_grant_id;
    logic               r_parity_en;
    logic               r_parity_type;
    logic               r_timeout_err;

    logic               w_any;
    logic [c_IDX_W-1:0] w_winner;
    logic [N_REQ-1:0]   w_onehot;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_accept;
    logic               w_timeout;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_any       (w_any),
        .o_winner    (w_winner),
        .o_onehot    (w_onehot)
    );

    // A winner in IDLE is always valid and ready, so any request means a transfer.
    assign w_accept  = (r_state == c_ST_IDLE) && w_any;
    assign w_timeout = (r_state == c_ST_WAIT_START) && !tx_busy && (r_cnt == c_CNT_LAST);

    // State register
    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) w_next_state = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_next_state = c_ST_WAIT_START;
            end
            c_ST_WAIT_START: begin
                if (tx_busy) begin
                    w_next_state = c_ST_WAIT_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!tx_busy) w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Outputs; gated by reset so nothing is offered while reset is asserted.
    always_comb begin
        req_ready     = '0;
        tx_data_valid = 1'b0;
        if (rst) begin
            case (r_state)
                c_ST_IDLE: req_ready     = w_onehot;
                c_ST_LOAD: tx_data_valid = 1'b1;
                default:   ;
            endcase
        end
    end

    // Byte of the winning requester
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == c_IDX_W'(i)) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame registers, priority pointer and start-timeout counter
    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_parity_en   <= 1'b0;
            r_parity_type <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_accept) begin
                r_tx_data     <= w_sel_data;
                r_grant_id    <= w_winner;
                r_parity_en   <= cfg_parity_en;
                r_parity_type <= cfg_parity_type;
                r_ptr         <= (w_winner == c_IDX_LAST) ? '0 : w_winner + c_IDX_W'(1);
            end
            if (r_state == c_ST_LOAD) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_WAIT_START) && !tx_busy && (r_cnt != c_CNT_LAST)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign tx_data        = r_tx_data;
    assign tx_parity_en   = r_parity_en;
    assign tx_parity_type = r_parity_type;
    assign grant_id       = r_grant_id;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. A small transmitter
//               model answers start pulses with a busy window; expected
//               frames are queued as stimulus is driven and compared on each
//               start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 16;
    localparam int IW = 2;

    logic            clk1 = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cfg_parity_en;
    logic            cfg_parity_type;
    logic [DW-1:0]   tx_data;
    logic            tx_data_valid;
    logic            tx_parity_en;
    logic            tx_parity_type;
    logic            tx_busy = 1'b0;
    logic [IW-1:0]   grant_id;
    logic            timeout_err;

    always #5 clk1 = ~clk1;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .DATA_W        (DW),
        .START_TIMEOUT (T)
    ) dut (
        .clk1            (clk1),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_type (cfg_parity_type),
        .tx_data         (tx_data),
        .tx_data_valid   (tx_data_valid),
        .tx_parity_en    (tx_parity_en),
        .tx_parity_type  (tx_parity_type),
        .tx_busy         (tx_busy),
        .grant_id        (grant_id),
        .timeout_err     (timeout_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [IW-1:0] gid;
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic exp_t mk(input int gid, input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_t e;
        e.gid  = IW'(gid);
        e.data = d;
        e.pe   = pe;
        e.pt   = pt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Transmitter model: busy rises 3 cycles after a start pulse and holds
    // for frame_len cycles. Disabling it forces busy low and clears it.
    logic tx_en     = 1'b0;
    int   t_del     = 0;
    int   t_len     = 0;
    int   frame_len = 100;

    always @(negedge clk1) begin
        if (!tx_en) begin
            tx_busy <= 1'b0;
            t_del   <= 0;
            t_len   <= 0;
        end else if (tx_data_valid === 1'b1) begin
            t_del <= 3;
        end else if (t_del > 1) begin
            t_del <= t_del - 1;
        end else if (t_del == 1) begin
            t_del   <= 0;
            tx_busy <= 1'b1;
            t_len   <= frame_len;
        end else if (t_len > 1) begin
            t_len <= t_len - 1;
        end else if (t_len == 1) begin
            t_len   <= 0;
            tx_busy <= 1'b0;
        end
    end

    // Scoreboard: every start pulse must match the oldest queued frame.
    always @(negedge clk1) begin
        if (tx_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_frame", {grant_id, tx_data, tx_parity_en, tx_parity_type}, mon_e);
            end
        end
    end

    task automatic step();
        @(negedge clk1);
        #1;
    endtask

    // Offer one byte from requester idx and hold it until it is accepted.
    task automatic send(input int idx, input logic [DW-1:0] d);
        bit seen = 1'b0;
        req_data[idx*DW +: DW] = d;
        req_valid[idx]         = 1'b1;
        for (int k = 0; k < 50 && !seen; k++) begin
            #1;
            if (req_ready[idx] === 1'b1) seen = 1'b1;
            step();
        end
        req_valid[idx] = 1'b0;
        check($sformatf("send%0d_accepted", idx), {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_busy_rise(input string tag);
        int k = 0;
        while (tx_busy !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        check({tag, "_busy_rise"}, {31'd0, tx_busy}, 32'd1);
    endtask

    task automatic wait_frame_end(input string tag);
        int k = 0;
        bit rose;
        while (tx_busy !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        rose = (tx_busy === 1'b1);
        while (tx_busy === 1'b1 && k < 400) begin
            step();
            k++;
        end
        check({tag, "_frame_end"}, {31'd0, (rose && tx_busy === 1'b0)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset with every requester asserting valid
        rst             = 1'b0;
        req_valid       = '1;
        req_data        = '0;
        cfg_parity_en   = 1'b0;
        cfg_parity_type = 1'b0;
        tx_en           = 1'b0;
        step();
        step();
        check("reset_req_ready", req_ready, 0);
        check("reset_data_valid", tx_data_valid, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_parity_en", tx_parity_en, 0);

        // Single request from requester 2
        rst       = 1'b1;
        tx_en     = 1'b1;
        req_valid = '0;
        step();
        sb.push_back(mk(2, 8'hA5, 1'b0, 1'b0));
        req_data[2*DW +: DW] = 8'hA5;
        req_valid            = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        #1;
        check("single_ready_drop", req_ready, 0);
        check("single_data_valid", tx_data_valid, 1);
        check("single_tx_data", tx_data, 8'hA5);
        check("single_grant_id", grant_id, 2);
        step();
        check("single_valid_one_cycle", tx_data_valid, 0);
        wait_frame_end("single");

        // Round robin from a fresh pointer, all requesters valid
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'(8'h10 + i);
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(i % N, DW'(8'h10 + (i % N)), 1'b0, 1'b0));
        end
        req_valid = '1;
        repeat (5) wait_frame_end("rr");
        req_valid = '0;
        step();
        check("rr_grant_hold", grant_id, 0);
        check("rr_idle_no_ready", req_ready, 0);

        // Parity config changed mid-frame applies to the next frame only
        cfg_parity_type = 1'b1;
        sb.push_back(mk(1, 8'h5A, 1'b0, 1'b1));
        send(1, 8'h5A);
        wait_busy_rise("cfg");
        cfg_parity_en = 1'b1;
        step();
        step();
        check("cfg_parity_en_hold", tx_parity_en, 0);
        check("cfg_parity_type", tx_parity_type, 1);
        wait_frame_end("cfg1");
        step();
        check("cfg_parity_en_idle_hold", tx_parity_en, 0);
        sb.push_back(mk(2, 8'hC3, 1'b1, 1'b1));
        send(2, 8'hC3);
        check("cfg_parity_en_new", tx_parity_en, 1);
        wait_frame_end("cfg2");

        // Start timeout: transmitter never goes busy
        tx_en = 1'b0;
        sb.push_back(mk(3, 8'h77, 1'b1, 1'b1));
        send(3, 8'h77);
        k = 0;
        while (timeout_err !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("timeout_latency", k, T + 1);
        check("timeout_grant_hold", grant_id, 3);
        step();
        check("timeout_pulse_width", timeout_err, 0);
        tx_en                = 1'b1;
        req_data[0*DW +: DW] = 8'h3C;
        req_data[3*DW +: DW] = 8'h99;
        req_valid            = 4'b1001;
        #1;
        check("timeout_next_grant", req_ready, 4'b0001);
        sb.push_back(mk(0, 8'h3C, 1'b1, 1'b1));
        step();
        req_valid = '0;

        // Reset in the middle of a frame
        wait_busy_rise("rst_mid");
        step();
        step();
        rst       = 1'b0;
        req_valid = 4'b1001;
        step();
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_data_valid", tx_data_valid, 0);
        check("rst_mid_tx_data", tx_data, 0);
        check("rst_mid_grant_id", grant_id, 0);
        check("rst_mid_parity", {tx_parity_en, tx_parity_type}, 0);
        tx_en = 1'b0;
        step();
        rst                  = 1'b1;
        tx_en                = 1'b1;
        req_data[0*DW +: DW] = 8'h4B;
        req_data[3*DW +: DW] = 8'hB4;
        #1;
        check("rst_ptr_zero_ready", req_ready, 4'b0001);
        sb.push_back(mk(0, 8'h4B, 1'b1, 1'b1));
        step();
        req_valid = '0;
        wait_frame_end("post_rst");
        step();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
